light_zone_controller: RTL and testbench
========================================

Name: light_zone_controller

Overview:
- Parametrised multi-zone successor to the single-output light automation FSM.
- Drives N independent light outputs from per-zone presence sensors and one shared ambient-dark input.
- Each zone runs its own OFF/ON/HOLD state machine with a hold-off timeout counted in prescaled ticks.
- Sits between the synchronised sensor inputs and the lamp drivers. It replaces the single-zone A/P controller and its external clock divider.

Parameters:
- N_ZONES, 4: number of independent zones, 1..32.
- TICK_DIV, 50000000: Clock cycles per timer tick, >= 2.
- HOLD_TICKS, 30: ticks a zone stays lit after presence drops, >= 1.

Ports:
- Clock  input  1  system clock; all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- Dark  input  1  ambient-dark indication, shared by all zones; 1 = dark.
- Presence  input  N_ZONES  per-zone occupancy; bit i = zone i occupied.
- Light  output  N_ZONES  per-zone lamp enable, registered.
- Any_On  output  1  OR of Light.
- Active_Count  output  $clog2(N_ZONES+1)  population count of Light.
- Tick  output  1  one-cycle prescaler strobe, for debug and verification.

Behaviour:
- Inputs are synchronous to Clock; synchronisers live upstream.
- Reset (synchronous, active-high), on the first posedge with Reset=1:
  - prescaler cleared to 0;
  - all zones go to OFF with timers cleared to 0;
  - Light=0, Any_On=0, Active_Count=0, Tick=0.
  - Reset takes priority over every other event, including mid-HOLD and mid-tick.
- Prescaler:
  - counter runs 0..TICK_DIV-1 and wraps to 0.
  - Tick is registered. It is 1 for exactly the cycle after the counter reaches TICK_DIV-1.
  - After Reset is released, the first Tick appears TICK_DIV cycles later.
- Per-zone FSM, encoded OFF=00, ON=01, HOLD=10. The illegal state 11 goes to OFF on the next edge. Transitions are evaluated every Clock cycle. Priority is top-down within each state:
  - OFF: Dark & Presence[i] -> ON. Otherwise stay in OFF.
  - ON: !Dark -> OFF. Else !Presence[i] -> HOLD, and timer loads HOLD_TICKS. Else stay in ON.
  - HOLD: !Dark -> OFF. Else Presence[i] -> ON, and the timer value is discarded. Else on Tick with timer==1 -> OFF. Else on Tick, timer decrements by 1. Otherwise hold.
- Timer:
  - width is $clog2(HOLD_TICKS+1);
  - it never underflows, because the timer==1 check precedes the decrement.
- Timeout span: a zone entering HOLD leaves it on the HOLD_TICKS-th Tick after entry. The hold time is therefore (HOLD_TICKS-1)*TICK_DIV+1 to HOLD_TICKS*TICK_DIV cycles, depending on prescaler phase.
- Outputs:
  - Light[i] = (state_i != OFF), taken directly from the state register.
  - Latency: an input change in cycle n is visible on Light in cycle n+1.
  - Any_On and Active_Count are combinational from Light and settle in the same cycle.
- Simultaneous events:
  - Dark falling while a zone is in HOLD, with Presence rising and Tick all in the same cycle -> OFF, because !Dark wins.
  - Presence and a Tick at timer==1 in the same cycle -> ON.
- Zones are fully independent. Only the prescaler and Dark are shared.

Optional Feature:
- Macro: LIGHT_ZONE_OVERRIDE_EN.
- Defined:
  - adds input ports Force_On[N_ZONES] and Force_Off[N_ZONES].
  - Force_Off[i]=1 drives zone i to OFF next edge and holds it there, regardless of Dark or Presence.
  - Otherwise Force_On[i]=1 drives zone i to ON next edge and holds it there, regardless of Dark.
  - When both are 1, Force_Off wins.
  - On release of a force, normal transitions resume from the current state. A zone released from Force_On with no presence enters HOLD with a full timer load.
- Undefined: the ports are absent, and behaviour is exactly as in Behaviour.

Test Plan (N_ZONES=4, TICK_DIV=4, HOLD_TICKS=3):
1. Reset high for 2 cycles, then release -> Light=4'b0000, Active_Count=0, Any_On=0; first Tick exactly 4 cycles after release, then every 4 cycles.
2. Dark=1, Presence=4'b0001 asserted in cycle n -> Light=4'b0001 in cycle n+1, Active_Count=1, Any_On=1; Presence=4'b0101 -> Light=4'b0101, Active_Count=2.
3. Zone 0 ON, Presence[0] drops -> Light[0] stays 1 through 2 Ticks and clears on the edge of the 3rd Tick; total lit time 9..12 cycles after the drop.
4. Zone 0 in HOLD after 2 Ticks, Presence[0] reasserted -> ON with no gap in Light[0]; the next drop again gives a full 3-Tick hold.
5. Zones 0 and 2 lit, Dark falls -> Light=4'b0000 next cycle; Presence=4'b1111 with Dark=0 held for 20 cycles -> Light stays 4'b0000.
6. Reset asserted mid-HOLD, coincident with a Tick -> all Light=0 next cycle, timers 0, prescaler restarts (Tick 4 cycles after release). With LIGHT_ZONE_OVERRIDE_EN: Force_On[3]=1, Dark=0 -> Light[3]=1; adding Force_Off[3]=1 -> Light[3]=0 next cycle.

Source files
------------

// File: rtl/light_zone_controller_if.sv
// Sensor/lamp bundle for the multi-zone light controller.
// Force_On/Force_Off exist only when LIGHT_ZONE_OVERRIDE_EN is defined.
interface light_zone_controller_if #(
    parameter int N_ZONES = 4
);
    localparam int CW = $clog2(N_ZONES + 1);

    logic               Dark;
    logic [N_ZONES-1:0] Presence;
`ifdef LIGHT_ZONE_OVERRIDE_EN
    logic [N_ZONES-1:0] Force_On;
    logic [N_ZONES-1:0] Force_Off;
`endif
    logic [N_ZONES-1:0] Light;
    logic               Any_On;
    logic [CW-1:0]      Active_Count;
    logic               Tick;

    modport master (
        output Dark,
        output Presence,
`ifdef LIGHT_ZONE_OVERRIDE_EN
        output Force_On,
        output Force_Off,
`endif
        input  Light,
        input  Any_On,
        input  Active_Count,
        input  Tick
    );

    modport slave (
        input  Dark,
        input  Presence,
`ifdef LIGHT_ZONE_OVERRIDE_EN
        input  Force_On,
        input  Force_Off,
`endif
        output Light,
        output Any_On,
        output Active_Count,
        output Tick
    );
endinterface

// File: rtl/light_zone_controller.sv
// N-zone OFF/ON/HOLD light controller with shared prescaler and Dark input.
// Optional per-zone overrides enabled by LIGHT_ZONE_OVERRIDE_EN.
module light_zone_controller #(
    parameter int N_ZONES    = 4,
    parameter int TICK_DIV   = 50000000,
    parameter int HOLD_TICKS = 30
) (
    input  logic Clock,
    input  logic Reset,
    light_zone_controller_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = $clog2(HOLD_TICKS + 1);
    localparam int CW = $clog2(N_ZONES + 1);

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        ON   = 2'b01,
        HOLD = 2'b10
    } state_t;

    logic [PW-1:0]      pre;
    logic               tick;
    state_t             st  [N_ZONES];
    logic [TW-1:0]      tmr [N_ZONES];
    logic [N_ZONES-1:0] light;
    logic [CW-1:0]      cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pre  <= '0;
            tick <= 1'b0;
            for (int i = 0; i < N_ZONES; i++) begin
                st[i]  <= OFF;
                tmr[i] <= '0;
            end
        end else begin
            tick <= (pre == PW'(TICK_DIV - 1));
            pre  <= (pre == PW'(TICK_DIV - 1)) ? '0 : pre + 1'b1;
            for (int i = 0; i < N_ZONES; i++) begin
`ifdef LIGHT_ZONE_OVERRIDE_EN
                if (bus.Force_Off[i])
                    st[i] <= OFF;
                else if (bus.Force_On[i])
                    st[i] <= ON;
                else
`endif
                begin
                    unique case (st[i])
                        OFF: begin
                            if (bus.Dark && bus.Presence[i])
                                st[i] <= ON;
                        end
                        ON: begin
                            if (!bus.Dark) begin
                                st[i] <= OFF;
                            end else if (!bus.Presence[i]) begin
                                st[i]  <= HOLD;
                                tmr[i] <= TW'(HOLD_TICKS);
                            end
                        end
                        HOLD: begin
                            // timer==1 is tested before decrement, so it never wraps
                            if (!bus.Dark)
                                st[i] <= OFF;
                            else if (bus.Presence[i])
                                st[i] <= ON;
                            else if (tick && tmr[i] == TW'(1))
                                st[i] <= OFF;
                            else if (tick)
                                tmr[i] <= tmr[i] - 1'b1;
                        end
                        default: st[i] <= OFF;
                    endcase
                end
            end
        end
    end

    always_comb begin
        light = '0;
        cnt   = '0;
        for (int i = 0; i < N_ZONES; i++) begin
            light[i] = (st[i] != OFF);
            cnt      = cnt + CW'(light[i]);
        end
    end

    assign bus.Light        = light;
    assign bus.Any_On       = |light;
    assign bus.Active_Count = cnt;
    assign bus.Tick         = tick;
endmodule

// File: tb/tb_light_zone_controller.sv
// Directed bench for light_zone_controller (N_ZONES=4, TICK_DIV=4, HOLD_TICKS=3).
// Override checks run when LIGHT_ZONE_OVERRIDE_EN is defined.
module tb_light_zone_controller;
    localparam int N = 4;

    typedef struct {
        logic       dark;
        logic [3:0] pres;
        logic [3:0] light;
        int         cnt;
        logic       any;
    } vec_t;

    logic Clock = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;

    light_zone_controller_if #(.N_ZONES(N)) bus ();

    light_zone_controller #(
        .N_ZONES(N),
        .TICK_DIV(4),
        .HOLD_TICKS(3)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_out(input string name, input logic [3:0] l,
                             input int c, input logic a);
        check({name, ".light"}, 32'(bus.Light), 32'(l));
        check({name, ".count"}, 32'(bus.Active_Count), 32'(c));
        check({name, ".any"}, 32'(bus.Any_On), 32'(a));
    endtask

    // Checks Tick pattern for 8 cycles right after Reset is released
    task automatic check_tick_phase(input string name);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("%s.tick%0d", name, k), 32'(bus.Tick),
                  32'((k % 4) == 0));
        end
    endtask

    // Steps until n Tick samples seen while zone 0 is lit
    task automatic wait_ticks(input string name, input int n);
        int seen = 0;
        int k = 0;
        while (seen < n && k < 40) begin
            step();
            k++;
            if (bus.Light[0] && bus.Tick) seen++;
        end
        check({name, ".wait_ticks"}, 32'(seen), 32'(n));
    endtask

    // Drops Presence[0] and measures the HOLD span
    task automatic measure_hold(input string name);
        int lit = 0;
        int ticks = 0;
        bus.Presence = 4'b0000;
        for (int k = 0; k < 40; k++) begin
            step();
            if (!bus.Light[0]) break;
            lit++;
            if (bus.Tick) ticks++;
        end
        check({name, ".lit_in_9_12"}, 32'(lit >= 9 && lit <= 12), 32'd1);
        check({name, ".ticks"}, 32'(ticks), 32'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[13];
        vt[0]  = '{1'b1, 4'b0001, 4'b0001, 1, 1'b1};
        vt[1]  = '{1'b1, 4'b0101, 4'b0101, 2, 1'b1};
        vt[2]  = '{1'b1, 4'b1111, 4'b1111, 4, 1'b1};
        vt[3]  = '{1'b0, 4'b1111, 4'b0000, 0, 1'b0};
        vt[4]  = '{1'b0, 4'b0000, 4'b0000, 0, 1'b0};
        vt[5]  = '{1'b1, 4'b0000, 4'b0000, 0, 1'b0};
        vt[6]  = '{1'b1, 4'b1010, 4'b1010, 2, 1'b1};
        vt[7]  = '{1'b1, 4'b1110, 4'b1110, 3, 1'b1};
        vt[8]  = '{1'b0, 4'b1110, 4'b0000, 0, 1'b0};
        vt[9]  = '{1'b1, 4'b0000, 4'b0000, 0, 1'b0};
        vt[10] = '{1'b1, 4'b0111, 4'b0111, 3, 1'b1};
        vt[11] = '{1'b1, 4'b0011, 4'b0111, 3, 1'b1};
        vt[12] = '{1'b0, 4'b0011, 4'b0000, 0, 1'b0};

        Reset        = 1'b1;
        bus.Dark     = 1'b0;
        bus.Presence = 4'b0000;
`ifdef LIGHT_ZONE_OVERRIDE_EN
        bus.Force_On  = 4'b0000;
        bus.Force_Off = 4'b0000;
`endif
        step();
        step();
        check_out("reset", 4'b0000, 0, 1'b0);
        check("reset.tick", 32'(bus.Tick), 32'd0);
        Reset = 1'b0;
        check_tick_phase("release");

        for (int i = 0; i < 13; i++) begin
            bus.Dark     = vt[i].dark;
            bus.Presence = vt[i].pres;
            step();
            check_out($sformatf("vec%0d", i), vt[i].light, vt[i].cnt,
                      vt[i].any);
        end

        // Hold timeout after presence drop
        bus.Dark     = 1'b1;
        bus.Presence = 4'b0001;
        step();
        check_out("hold.on", 4'b0001, 1, 1'b1);
        measure_hold("hold1");
        check_out("hold1.off", 4'b0000, 0, 1'b0);

        // Re-entry after 2 ticks, then full hold again
        bus.Presence = 4'b0001;
        step();
        bus.Presence = 4'b0000;
        wait_ticks("reenter", 2);
        bus.Presence = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("reenter.lit%0d", k), 32'(bus.Light[0]), 32'd1);
        end
        measure_hold("hold2");

        // Presence coincident with the final tick keeps the zone on
        bus.Presence = 4'b0001;
        step();
        bus.Presence = 4'b0000;
        wait_ticks("lasttick", 3);
        bus.Presence = 4'b0001;
        step();
        check("lasttick.on", 32'(bus.Light[0]), 32'd1);
        for (int k = 0; k < 12; k++) step();
        check("lasttick.stay", 32'(bus.Light[0]), 32'd1);

        // Dark falling clears every zone, presence alone cannot relight
        bus.Presence = 4'b0101;
        step();
        check_out("dark.lit", 4'b0101, 2, 1'b1);
        bus.Dark = 1'b0;
        step();
        check_out("dark.fall", 4'b0000, 0, 1'b0);
        bus.Presence = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("daylight%0d", k), 32'(bus.Light), 32'd0);
        end

        // Reset mid-HOLD on the edge that would raise Tick
        bus.Dark     = 1'b1;
        bus.Presence = 4'b0001;
        step();
        bus.Presence = 4'b0000;
        wait_ticks("rst", 1);
        step();
        step();
        step();
        check("rst.still_hold", 32'(bus.Light[0]), 32'd1);
        Reset = 1'b1;
        step();
        check_out("rst.mid", 4'b0000, 0, 1'b0);
        check("rst.tick", 32'(bus.Tick), 32'd0);
        Reset = 1'b0;
        check_tick_phase("rst_release");
        check("rst.stay_off", 32'(bus.Light), 32'd0);

`ifdef LIGHT_ZONE_OVERRIDE_EN
        bus.Dark     = 1'b0;
        bus.Presence = 4'b0000;
        bus.Force_On = 4'b1000;
        step();
        check_out("force_on", 4'b1000, 1, 1'b1);
        step();
        check_out("force_on.hold", 4'b1000, 1, 1'b1);
        bus.Force_Off = 4'b1000;
        step();
        check_out("force_both", 4'b0000, 0, 1'b0);
        bus.Force_On  = 4'b0000;
        bus.Force_Off = 4'b0000;
        step();
        check_out("force_release", 4'b0000, 0, 1'b0);
        bus.Dark     = 1'b1;
        bus.Force_On = 4'b0010;
        step();
        check_out("force_on1", 4'b0010, 1, 1'b1);
        bus.Force_On = 4'b0000;
        step();
        check("force_rel.hold", 32'(bus.Light[1]), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
